// File: rtl/multi_cycle_issue_scheduler_pkg.sv
// Shared types and sizing for the multi-cycle FP/IMUL issue scheduler.
// The in-flight tracker entry mirrors one stage of the multi-cycle pipeline.
package multi_cycle_issue_scheduler_pkg;

    localparam int THREADS_PER_CORE = 4;
    localparam int MS_STAGE_COUNT   = 5;
    localparam int PIPE_DEPTH       = MS_STAGE_COUNT;
    localparam int REG_IDX_WIDTH    = 5;
    localparam int THREAD_IDX_WIDTH = $clog2(THREADS_PER_CORE);

    typedef logic [THREAD_IDX_WIDTH-1:0] thread_idx_t;
    typedef logic [REG_IDX_WIDTH-1:0]    reg_idx_t;
    typedef logic [REG_IDX_WIDTH:0]      reg_tag_t;

    typedef struct packed {
        logic        valid;
        thread_idx_t thread_idx;
        reg_idx_t    dest;
        logic        dest_vector;
    } ms_entry_t;

    // Register-file select is part of the identity of a register.
    function automatic reg_tag_t reg_tag(input logic vec, input reg_idx_t idx);
        return {vec, idx};
    endfunction

endpackage

// File: rtl/multi_cycle_issue_scheduler_rr_arbiter.sv
// One-hot round-robin arbiter; priority starts one past the last winner.
// The winner is remembered only when update_en_i is set.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NUM_REQ-1:0] request_i,
    input  logic               update_en_i,
    output logic [NUM_REQ-1:0] grant_oh_o
);

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] last_d;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand_idx;
    logic             found;
    int               cand;

    always_comb begin
        grant_oh_o = '0;
        found      = 1'b0;
        win_idx    = last_q;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand     = (int'(last_q) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && request_i[cand_idx]) begin
                found   = 1'b1;
                win_idx = cand_idx;
            end
        end
        if (found) begin
            grant_oh_o[win_idx] = 1'b1;
        end
        last_d = (update_en_i && found) ? win_idx : last_q;
    end

    // Reset to the top index so requester 0 wins first.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/multi_cycle_issue_scheduler.sv
// Round-robin issue into the shared multi-cycle pipeline with per-thread
// RAW/WAW blocking against in-flight entries and rollback squash.
module multi_cycle_issue_scheduler
    import multi_cycle_issue_scheduler_pkg::*;
(
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic [THREADS_PER_CORE-1:0]                      rq_valid,
    input  logic [THREADS_PER_CORE-1:0][REG_IDX_WIDTH-1:0]   rq_dest,
    input  logic [THREADS_PER_CORE-1:0]                      rq_dest_vector,
    input  logic [THREADS_PER_CORE-1:0][REG_IDX_WIDTH-1:0]   rq_src1,
    input  logic [THREADS_PER_CORE-1:0][REG_IDX_WIDTH-1:0]   rq_src2,
    input  logic [THREADS_PER_CORE-1:0]                      rq_src1_vector,
    input  logic [THREADS_PER_CORE-1:0]                      rq_src2_vector,
    input  logic [THREADS_PER_CORE-1:0]                      rq_src1_used,
    input  logic [THREADS_PER_CORE-1:0]                      rq_src2_used,
    output logic [THREADS_PER_CORE-1:0]                      rq_grant,
    input  logic                                             rollback_en,
    input  thread_idx_t                                      rollback_thread_idx,
    output logic                                             ms_issue_valid,
    output thread_idx_t                                      ms_issue_thread_idx,
    output logic [THREADS_PER_CORE-1:0]                      ms_busy
);

    ms_entry_t [PIPE_DEPTH-1:0] trk_q;
    ms_entry_t [PIPE_DEPTH-1:0] trk_d;

    logic [THREADS_PER_CORE-1:0][PIPE_DEPTH-1:0] hit;
    logic [THREADS_PER_CORE-1:0][PIPE_DEPTH-1:0] owns;
    logic [THREADS_PER_CORE-1:0]                 hazard;
    logic [THREADS_PER_CORE-1:0]                 squash;
    logic [THREADS_PER_CORE-1:0]                 eligible;
    logic [THREADS_PER_CORE-1:0]                 grant;
    thread_idx_t                                 gnt_idx;

    logic        ms_issue_valid_q;
    thread_idx_t ms_issue_thread_idx_q;

    for (genvar t = 0; t < THREADS_PER_CORE; t++) begin : g_thread
        localparam thread_idx_t TID = thread_idx_t'(t);
        for (genvar e = 0; e < PIPE_DEPTH; e++) begin : g_entry
            reg_tag_t etag;
            assign etag = reg_tag(trk_q[e].dest_vector, trk_q[e].dest);
            assign owns[t][e] = trk_q[e].valid && (trk_q[e].thread_idx == TID);
            assign hit[t][e] = owns[t][e] && (
                (etag == reg_tag(rq_dest_vector[t], rq_dest[t])) ||
                (rq_src1_used[t] && etag == reg_tag(rq_src1_vector[t], rq_src1[t])) ||
                (rq_src2_used[t] && etag == reg_tag(rq_src2_vector[t], rq_src2[t])));
        end
        assign hazard[t]   = |hit[t];
        assign squash[t]   = rollback_en && (rollback_thread_idx == TID);
        assign eligible[t] = rq_valid[t] && !hazard[t] && !squash[t];
        assign ms_busy[t]  = |owns[t];
    end

    rr_arbiter #(
        .NUM_REQ(THREADS_PER_CORE)
    ) u_arb (
        .clk_i      (clk),
        .reset_i    (reset),
        .request_i  (eligible),
        .update_en_i(|eligible),
        .grant_oh_o (grant)
    );

    assign rq_grant = grant;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < THREADS_PER_CORE; i++) begin
            if (grant[i]) begin
                gnt_idx = thread_idx_t'(i);
            end
        end
    end

    // Rollback clears the victim's entries as they shift; the tail retires.
    always_comb begin
        trk_d[0].valid       = |grant;
        trk_d[0].thread_idx  = gnt_idx;
        trk_d[0].dest        = rq_dest[gnt_idx];
        trk_d[0].dest_vector = rq_dest_vector[gnt_idx];
        for (int e = 1; e < PIPE_DEPTH; e++) begin
            trk_d[e] = trk_q[e-1];
            if (rollback_en && trk_q[e-1].thread_idx == rollback_thread_idx) begin
                trk_d[e].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trk_q                 <= '0;
            ms_issue_valid_q      <= 1'b0;
            ms_issue_thread_idx_q <= '0;
        end else begin
            trk_q            <= trk_d;
            ms_issue_valid_q <= |grant;
            if (|grant) begin
                ms_issue_thread_idx_q <= gnt_idx;
            end
        end
    end

    assign ms_issue_valid      = ms_issue_valid_q;
    assign ms_issue_thread_idx = ms_issue_thread_idx_q;

endmodule
